// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment digit sequencer.
package ssd_pkg;

    localparam int unsigned SEL_W      = 3;
    localparam int unsigned MAX_DIGITS = 8;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused
    } state_e;

    typedef struct packed {
        sel_t sel;
        logic wrapped;
    } step_t;

    // One up/down step within 0..last, flagging when the range end is crossed.
    function automatic step_t next_sel(input sel_t cur, input logic down, input sel_t last);
        step_t res;
        if (down) begin
            res.wrapped = (cur == '0);
            res.sel     = res.wrapped ? last : cur - sel_t'(1);
        end else begin
            res.wrapped = (cur == last);
            res.sel     = res.wrapped ? '0 : cur + sel_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick_o on the last count.
module ssd_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssd_digit_sequencer.sv
// Steps a digit index for a multiplexed SSD decoder, with start/pause/single-step
// control and an optional stop at the end of the digit range.
module ssd_digit_sequencer
    import ssd_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned LOOP       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             dir,
    output logic [SEL_W-1:0] selector_out,
    output logic             running,
    output logic             tick,
    output logic             wrap_pulse
);

    localparam sel_t LastSel = sel_t'(NUM_DIGITS - 1);

    state_e state_q, state_d;
    sel_t   sel_q, sel_d;
    logic   tick_q, tick_d;
    logic   wrap_q, wrap_d;
    logic   start_q, step_q;

    logic  start_rise, step_rise;
    logic  presc_en, presc_clr, presc_tick;
    logic  do_step;
    step_t nxt;

    ssd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (presc_en),
        .clr    (presc_clr),
        .tick_o (presc_tick)
    );

    always_comb begin
        start_rise = start & ~start_q;
        step_rise  = step & ~step_q;
        nxt        = next_sel(sel_q, dir, LastSel);
        state_d    = state_q;
        sel_d      = sel_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        presc_en   = 1'b0;
        presc_clr  = 1'b0;
        do_step    = 1'b0;

        if (start_rise) begin
            state_d   = StRun;
            presc_clr = 1'b1;
            sel_d     = dir ? LastSel : '0;
        end else begin
            unique case (state_q)
                StIdle: presc_clr = 1'b1;
                StRun: begin
                    // Pause outranks a prescaler step landing in the same cycle.
                    if (pause) begin
                        state_d = StPaused;
                    end else begin
                        presc_en = 1'b1;
                        do_step  = presc_tick;
                    end
                end
                StPaused: begin
                    if (!pause) begin
                        state_d = StRun;
                    end else begin
                        do_step = step_rise;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (do_step) begin
            tick_d = 1'b1;
            wrap_d = nxt.wrapped;
            // Without looping, the wrapping step holds the last digit and stops.
            if (nxt.wrapped && (LOOP == 0)) begin
                state_d = StIdle;
            end else begin
                sel_d = nxt.sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            start_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            start_q <= start;
            step_q  <= step;
        end
    end

    assign selector_out = sel_q;
    assign running      = (state_q == StRun);
    assign tick         = tick_q;
    assign wrap_pulse   = wrap_q;

endmodule

// File: tb/tb_ssd_digit_sequencer.sv
// Directed bench: a looping and a non-looping sequencer share one set of inputs.
module tb_ssd_digit_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, pause, step, dir;
    logic [2:0] sel1, sel2;
    logic       run1, run2, tick1, tick2, wrap1, wrap2;

    int checks = 0;
    int errors = 0;
    int seen;

    always #5 clk = ~clk;

    ssd_digit_sequencer #(
        .TICK_DIV   (4),
        .NUM_DIGITS (8),
        .LOOP       (1)
    ) u_dut_loop (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause        (pause),
        .step         (step),
        .dir          (dir),
        .selector_out (sel1),
        .running      (run1),
        .tick         (tick1),
        .wrap_pulse   (wrap1)
    );

    ssd_digit_sequencer #(
        .TICK_DIV   (4),
        .NUM_DIGITS (8),
        .LOOP       (0)
    ) u_dut_stop (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause        (pause),
        .step         (step),
        .dir          (dir),
        .selector_out (sel2),
        .running      (run2),
        .tick         (tick2),
        .wrap_pulse   (wrap2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        step  = 1'b0;
        dir   = 1'b0;
        #2;
        check("rst_sel", 32'(sel1), 0);
        check("rst_running", 32'(run1), 0);
        check("rst_tick", 32'(tick1), 0);
        check("rst_wrap", 32'(wrap1), 0);

        // Idle after reset release with all inputs low
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (tick1 || run1) seen++;
        end
        check("idle_sel", 32'(sel1), 0);
        check("idle_running", 32'(run1), 0);
        check("idle_tick_or_run_seen", 32'(seen), 0);

        // Up count, one full lap
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("up_start_running", 32'(run1), 1);
        check("up_start_sel", 32'(sel1), 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(3);
            check($sformatf("up_notick_%0d", k), 32'(tick1), 0);
            cyc(1);
            check($sformatf("up_sel_%0d", k), 32'(sel1), 32'(k % 8));
            check($sformatf("up_tick_%0d", k), 32'(tick1), 1);
            check($sformatf("up_wrap_%0d", k), 32'(wrap1), (k == 8) ? 1 : 0);
        end

        // Down count, one full lap
        dir   = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("dn_start_sel", 32'(sel1), 7);
        for (int k = 1; k <= 8; k++) begin
            cyc(4);
            check($sformatf("dn_sel_%0d", k), 32'(sel1), 32'((15 - k) % 8));
            check($sformatf("dn_wrap_%0d", k), 32'(wrap1), (k == 8) ? 1 : 0);
        end

        // Pause at 3 with one prescaler count already spent, then single steps
        dir   = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(12);
        check("ps_sel3", 32'(sel1), 3);
        cyc(1);
        pause = 1'b1;
        seen  = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (tick1) seen++;
        end
        check("ps_hold_sel", 32'(sel1), 3);
        check("ps_running", 32'(run1), 0);
        check("ps_no_ticks", 32'(seen), 0);
        step = 1'b1;
        cyc(1);
        check("ps_step1_sel", 32'(sel1), 4);
        check("ps_step1_tick", 32'(tick1), 1);
        step = 1'b0;
        cyc(1);
        check("ps_step1_tick_drop", 32'(tick1), 0);
        step = 1'b1;
        cyc(1);
        check("ps_step2_sel", 32'(sel1), 5);
        check("ps_step2_tick", 32'(tick1), 1);
        step = 1'b0;
        cyc(1);
        pause = 1'b0;
        cyc(1);
        check("ps_resume_running", 32'(run1), 1);
        cyc(2);
        check("ps_resume_held", 32'(sel1), 5);
        cyc(1);
        check("ps_resume_sel", 32'(sel1), 6);
        check("ps_resume_tick", 32'(tick1), 1);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("run_step_ignored", 32'(sel1), 6);

        // Non-looping instance stops at the last digit
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("stop_start_sel", 32'(sel2), 0);
        check("stop_start_running", 32'(run2), 1);
        cyc(28);
        check("stop_sel7", 32'(sel2), 7);
        check("stop_sel7_wrap", 32'(wrap2), 0);
        cyc(4);
        check("stop_end_sel", 32'(sel2), 7);
        check("stop_end_tick", 32'(tick2), 1);
        check("stop_end_wrap", 32'(wrap2), 1);
        check("stop_end_running", 32'(run2), 0);
        check("loop_wrap_sel", 32'(sel1), 0);
        check("loop_wrap_pulse", 32'(wrap1), 1);
        for (int i = 0; i < 2; i++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            cyc(1);
        end
        check("stop_idle_step_sel", 32'(sel2), 7);
        check("stop_idle_running", 32'(run2), 0);

        // Start and pause together while paused, then asynchronous reset mid-run
        check("pre_pause_sel1", 32'(sel1), 1);
        cyc(4);
        check("pre_pause_sel2", 32'(sel1), 2);
        pause = 1'b1;
        cyc(1);
        check("sim_paused", 32'(run1), 0);
        check("sim_paused_sel", 32'(sel1), 2);
        start = 1'b1;
        cyc(1);
        check("sim_running", 32'(run1), 1);
        check("sim_sel", 32'(sel1), 0);
        start = 1'b0;
        pause = 1'b0;
        cyc(4);
        check("mid_sel", 32'(sel1), 1);
        check("mid_tick", 32'(tick1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel1), 0);
        check("arst_running", 32'(run1), 0);
        check("arst_tick", 32'(tick1), 0);
        check("arst_wrap", 32'(wrap1), 0);
        check("arst_sel_stop", 32'(sel2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
